hilo_muldiv_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit that owns the HI/LO architectural registers.
- Sits beside the ALU in the Execute stage.
- Handles MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB and MSUBU with a start/busy/done handshake.
- Supports direct HI/LO writes (MTHI/MTLO) and HI/LO reads (MFHI/MFLO). The hazard unit stalls on Busy.

---
 rtl/hilo_muldiv_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//
// Multi-cycle multiply/divide unit that owns the HI/LO architectural
// registers. It sits beside the ALU in the Execute stage and runs MULT,
// MULTU, DIV, DIVU, MADD, MADDU, MSUB and MSUBU behind a start/busy/done
// handshake. It also services MTHI/MTLO writes and MFHI/MFLO reads.
//
// Ports:
//   Clk        in   1      clock, rising edge
//   Rst        in   1      synchronous active-high reset
//   Start      in   1      launch Op (accepted only while Busy=0)
//   Op         in   3      000 MULT 001 MULTU 010 DIV 011 DIVU
//                          100 MADD 101 MADDU 110 MSUB 111 MSUBU
//   OperandA   in   WIDTH  multiplicand / dividend (rs)
//   OperandB   in   WIDTH  multiplier / divisor (rt)
//   HiWrite    in   1      MTHI: load WriteData into HI
//   LoWrite    in   1      MTLO: load WriteData into LO
//   WriteData  in   WIDTH  data for MTHI/MTLO
//   Busy       out  1      operation in flight
//   Done       out  1      one-cycle pulse, HI/LO already hold the result
//   DivByZero  out  1      DIV/DIVU divisor was zero (held until next Start)
//   ReadHi     out  WIDTH  current HI
//   ReadLo     out  WIDTH  current LO
//
// Optional feature: define HILO_BYPASS_EN to forward MTHI/MTLO write data
// combinationally onto ReadHi/ReadLo in the cycle the write is issued.

module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] WriteData,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] ReadHi,
    output logic [WIDTH-1:0] ReadLo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         kind_q, kind_d;
    logic               signA_q, signA_d;
    logic               signB_q, signB_d;
    logic [WIDTH-1:0]   opA_q, opA_d;
    logic [WIDTH-1:0]   magB_q, magB_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      count_q, count_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               startSigned;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magBStart;
    logic               kindDiv;
    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] mulNext;
    logic [WIDTH:0]     remShift;
    logic               remFits;
    logic [WIDTH-1:0]   remDiff;
    logic [2*WIDTH-1:0] divNext;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] base;
    logic [2*WIDTH-1:0] fixResult;

    // Datapath. The accumulator holds {partial, multiplier} while multiplying
    // and {remainder, quotient} while dividing, so both algorithms share one
    // 2*WIDTH register and the same initial load of {0, |OperandA|}.
    // Only Op[2:1] is kept: signedness is folded into the stored sign flags.
    always_comb begin
        startSigned = ~Op[0];
        magA        = (startSigned && OperandA[WIDTH-1]) ? -OperandA : OperandA;
        magBStart   = (startSigned && OperandB[WIDTH-1]) ? -OperandB : OperandB;
        kindDiv     = ~kind_q[1] & kind_q[0];

        // Shift-add step: the carry out of the add lands in the top bit
        // as the whole pair shifts right by one.
        mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, magB_q} : '0);
        mulNext = {mulSum, acc_q[WIDTH-1:1]};

        // Restoring step: the shifted remainder needs one extra bit before
        // the trial subtract; the difference itself always fits in WIDTH.
        remShift = acc_q[2*WIDTH-1:WIDTH-1];
        remFits  = remShift >= {1'b0, magB_q};
        remDiff  = remShift[WIDTH-1:0] - magB_q;
        divNext  = remFits ? {remDiff, acc_q[WIDTH-2:0], 1'b1}
                           : {acc_q[2*WIDTH-2:0], 1'b0};

        // Sign correction: quotient/product negative when signs differ,
        // remainder follows the dividend.
        product = (signA_q ^ signB_q) ? -acc_q : acc_q;
        quot    = (signA_q ^ signB_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem     = signA_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        base    = {hi_q, lo_q};

        if (kindDiv) begin
            fixResult = (magB_q == '0) ? {opA_q, {WIDTH{1'b1}}} : {rem, quot};
        end else if (kind_q[1]) begin
            fixResult = kind_q[0] ? (base - product) : (base + product);
        end else begin
            fixResult = product;
        end
    end

    // Next-state logic. MTHI/MTLO apply in every state; the FIX-cycle
    // result write comes later in the block so it overrides them.
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        signA_d = signA_q;
        signB_d = signB_q;
        opA_d   = opA_q;
        magB_d  = magB_q;
        acc_d   = acc_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;

        if (HiWrite) begin
            hi_d = WriteData;
        end
        if (LoWrite) begin
            lo_d = WriteData;
        end

        case (state_q)
            IDLE: begin
                if (Start) begin
                    kind_d  = Op[2:1];
                    signA_d = startSigned & OperandA[WIDTH-1];
                    signB_d = startSigned & OperandB[WIDTH-1];
                    opA_d   = OperandA;
                    magB_d  = magBStart;
                    acc_d   = {{WIDTH{1'b0}}, magA};
                    count_d = CW'(WIDTH);
                    dbz_d   = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d   = kindDiv ? divNext : mulNext;
                count_d = count_q - 1'b1;
                if (count_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                {hi_d, lo_d} = fixResult;
                done_d       = 1'b1;
                dbz_d        = kindDiv && (magB_q == '0);
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any operation without touching
    // anything beyond clearing it.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            kind_q  <= '0;
            signA_q <= 1'b0;
            signB_q <= 1'b0;
            opA_q   <= '0;
            magB_q  <= '0;
            acc_q   <= '0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            signA_q <= signA_d;
            signB_q <= signB_d;
            opA_q   <= opA_d;
            magB_q  <= magB_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign Busy      = (state_q != IDLE);
    assign Done      = done_q;
    assign DivByZero = dbz_q;

`ifdef HILO_BYPASS_EN
    assign ReadHi = HiWrite ? WriteData : hi_q;
    assign ReadLo = LoWrite ? WriteData : lo_q;
`else
    assign ReadHi = hi_q;
    assign ReadLo = lo_q;
`endif

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit
//
// Self-checking bench for hilo_muldiv_unit (WIDTH=32). Directed scenarios
// cover timing, back-to-back issue, divide corner cases, accumulate with
// MTHI/MTLO interaction, ignored Start, reset abort and write visibility;
// a randomized pass compares against a 64-bit arithmetic reference model.

module tb_hilo_muldiv_unit;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         Start;
    logic [2:0]   Op;
    logic [W-1:0] OperandA;
    logic [W-1:0] OperandB;
    logic         HiWrite;
    logic         LoWrite;
    logic [W-1:0] WriteData;
    logic         Busy;
    logic         Done;
    logic         DivByZero;
    logic [W-1:0] ReadHi;
    logic [W-1:0] ReadLo;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] mHi;
    logic [W-1:0] mLo;

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .Op        (Op),
        .OperandA  (OperandA),
        .OperandB  (OperandB),
        .HiWrite   (HiWrite),
        .LoWrite   (LoWrite),
        .WriteData (WriteData),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero),
        .ReadHi    (ReadHi),
        .ReadLo    (ReadLo)
    );

    always #5 Clk = ~Clk;

    // Reference model: plain 64-bit arithmetic on the instruction semantics.
    function automatic void modelOp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [W-1:0] baseHi, input logic [W-1:0] baseLo,
                                    output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dbz);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, bs;
        logic [63:0]     res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        bs  = {baseHi, baseLo};
        dbz = 1'b0;
        case (op)
            3'b000: res = sa * sb;
            3'b001: res = ua * ub;
            3'b100: res = bs + sa * sb;
            3'b101: res = bs + ua * ub;
            3'b110: res = bs - sa * sb;
            3'b111: res = bs - ua * ub;
            3'b010: begin
                if (b == 0) begin
                    res = {a, 32'hFFFF_FFFF};
                    dbz = 1'b1;
                end else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) begin
                    res = {a, 32'hFFFF_FFFF};
                    dbz = 1'b1;
                end else begin
                    res = {32'(ua % ub), 32'(ua / ub)};
                end
            end
        endcase
        hi = res[63:32];
        lo = res[31:0];
    endfunction

    // Launch one operation from just after a falling edge and wait (bounded)
    // for Done. cycles = edges after the start edge at which Done is seen
    // (0 if never). Optional MTHI/MTLO at wrCycle and a spurious Start at
    // spamCycle. Operands are scrambled after launch to prove they are latched.
    task automatic runOp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int wrCycle, input logic hiW, input logic loW, input logic [W-1:0] wdata,
                         input int spamCycle, output int cycles, output logic busyOk);
        Start    = 1'b1;
        Op       = op;
        OperandA = a;
        OperandB = b;
        busyOk   = 1'b1;
        cycles   = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge Clk);
            Start    = 1'b0;
            HiWrite  = 1'b0;
            LoWrite  = 1'b0;
            OperandA = $urandom;
            OperandB = $urandom;
            if (Done) begin
                cycles = c;
                break;
            end
            if (Busy !== 1'b1) busyOk = 1'b0;
            if (c == wrCycle) begin
                HiWrite   = hiW;
                LoWrite   = loW;
                WriteData = wdata;
            end
            if (c == spamCycle) begin
                Start = 1'b1;
                Op    = ~op;
            end
        end
    endtask

    task automatic test_reset();
        Rst       = 1'b1;
        Start     = 1'b0;
        Op        = 3'b000;
        OperandA  = '0;
        OperandB  = '0;
        HiWrite   = 1'b0;
        LoWrite   = 1'b0;
        WriteData = '0;
        repeat (3) @(negedge Clk);
        checks++;
        if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", Busy); end
        checks++;
        if (Done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", Done); end
        checks++;
        if (DivByZero !== 1'b0) begin failures++; $display("[TB] FAIL reset_dbz: got %b expected 0", DivByZero); end
        checks++;
        if ({ReadHi, ReadLo} !== 64'h0) begin failures++; $display("[TB] FAIL reset_hilo: got %h_%h expected 0_0", ReadHi, ReadLo); end
        Rst = 1'b0;
        mHi = '0;
        mLo = '0;
        @(negedge Clk);
    endtask

    task automatic test_mult_timing();
        int   cyc;
        logic bok;
        runOp(3'b000, 32'hFFFF_FFFD, 32'd7, 0, 1'b0, 1'b0, '0, 0, cyc, bok);
        checks++;
        if (cyc !== 34) begin failures++; $display("[TB] FAIL mult_latency: got %0d expected 34", cyc); end
        checks++;
        if (bok !== 1'b1) begin failures++; $display("[TB] FAIL mult_busy: got %b expected 1 throughout", bok); end
        checks++;
        if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL mult_busy_done: got %b expected 0", Busy); end
        checks++;
        if ({ReadHi, ReadLo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            failures++; $display("[TB] FAIL mult_result: got %h_%h expected ffffffff_ffffffeb", ReadHi, ReadLo);
        end
        mHi = 32'hFFFF_FFFF;
        mLo = 32'hFFFF_FFEB;
        @(negedge Clk);
        checks++;
        if (Done !== 1'b0) begin failures++; $display("[TB] FAIL done_pulse: got %b expected 0", Done); end
    endtask

    task automatic test_back_to_back();
        int           cyc;
        logic         bok;
        logic [W-1:0] eh, el;
        logic         ed;
        runOp(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, '0, 0, cyc, bok);
        checks++;
        if ({ReadHi, ReadLo} !== 64'hFFFF_FFFE_0000_0001) begin
            failures++; $display("[TB] FAIL multu_result: got %h_%h expected fffffffe_00000001", ReadHi, ReadLo);
        end
        mHi = 32'hFFFF_FFFE;
        mLo = 32'h0000_0001;
        // Launch straight from the Done cycle.
        modelOp(3'b000, 32'd12345, 32'hFFFF_FFFE, mHi, mLo, eh, el, ed);
        runOp(3'b000, 32'd12345, 32'hFFFF_FFFE, 0, 1'b0, 1'b0, '0, 0, cyc, bok);
        checks++;
        if (cyc !== 34) begin failures++; $display("[TB] FAIL b2b_latency: got %0d expected 34", cyc); end
        checks++;
        if ({ReadHi, ReadLo} !== {eh, el}) begin
            failures++; $display("[TB] FAIL b2b_result: got %h_%h expected %h_%h", ReadHi, ReadLo, eh, el);
        end
        mHi = eh;
        mLo = el;
    endtask

    task automatic test_div();
        int   cyc;
        logic bok;
        runOp(3'b010, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, 1'b0, '0, 0, cyc, bok);
        checks++;
        if ({ReadHi, ReadLo, DivByZero} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0}) begin
            failures++; $display("[TB] FAIL div_neg7_2: got %h_%h dbz=%b expected ffffffff_fffffffd dbz=0", ReadHi, ReadLo, DivByZero);
        end
        runOp(3'b011, 32'd7, 32'd0, 0, 1'b0, 1'b0, '0, 0, cyc, bok);
        checks++;
        if (cyc !== 34) begin failures++; $display("[TB] FAIL divz_latency: got %0d expected 34", cyc); end
        checks++;
        if ({ReadHi, ReadLo, DivByZero} !== {32'h0000_0007, 32'hFFFF_FFFF, 1'b1}) begin
            failures++; $display("[TB] FAIL divu_by_zero: got %h_%h dbz=%b expected 00000007_ffffffff dbz=1", ReadHi, ReadLo, DivByZero);
        end
        repeat (3) @(negedge Clk);
        checks++;
        if (DivByZero !== 1'b1) begin failures++; $display("[TB] FAIL dbz_hold: got %b expected 1", DivByZero); end
        runOp(3'b010, 32'hFFFF_FFF9, 32'd0, 0, 1'b0, 1'b0, '0, 0, cyc, bok);
        checks++;
        if ({ReadHi, ReadLo, DivByZero} !== {32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1}) begin
            failures++; $display("[TB] FAIL div_signed_by_zero: got %h_%h dbz=%b expected fffffff9_ffffffff dbz=1", ReadHi, ReadLo, DivByZero);
        end
        runOp(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, '0, 0, cyc, bok);
        checks++;
        if ({ReadHi, ReadLo, DivByZero} !== {32'h0, 32'h8000_0000, 1'b0}) begin
            failures++; $display("[TB] FAIL div_overflow: got %h_%h dbz=%b expected 00000000_80000000 dbz=0", ReadHi, ReadLo, DivByZero);
        end
        mHi = 32'h0;
        mLo = 32'h8000_0000;
    endtask

    task automatic test_madd_msub();
        int   cyc;
        logic bok;
        @(negedge Clk);
        HiWrite   = 1'b1;
        WriteData = 32'd0;
        @(negedge Clk);
        HiWrite   = 1'b0;
        LoWrite   = 1'b1;
        WriteData = 32'd5;
        @(negedge Clk);
        LoWrite   = 1'b0;
        runOp(3'b100, 32'd2, 32'd3, 0, 1'b0, 1'b0, '0, 0, cyc, bok);
        checks++;
        if ({ReadHi, ReadLo} !== 64'h0000_0000_0000_000B) begin
            failures++; $display("[TB] FAIL madd: got %h_%h expected 00000000_0000000b", ReadHi, ReadLo);
        end
        runOp(3'b110, 32'd4, 32'd4, 0, 1'b0, 1'b0, '0, 0, cyc, bok);
        checks++;
        if ({ReadHi, ReadLo} !== 64'hFFFF_FFFF_FFFF_FFFB) begin
            failures++; $display("[TB] FAIL msub: got %h_%h expected ffffffff_fffffffb", ReadHi, ReadLo);
        end
        // MTLO during CALC becomes part of the accumulate base.
        runOp(3'b101, 32'd1, 32'd1, 5, 1'b0, 1'b1, 32'h100, 0, cyc, bok);
        checks++;
        if ({ReadHi, ReadLo} !== 64'hFFFF_FFFF_0000_0101) begin
            failures++; $display("[TB] FAIL madd_midwrite: got %h_%h expected ffffffff_00000101", ReadHi, ReadLo);
        end
        // MTLO in the FIX cycle loses to the result.
        runOp(3'b001, 32'd2, 32'd3, 33, 1'b0, 1'b1, 32'hDEAD, 0, cyc, bok);
        checks++;
        if ({ReadHi, ReadLo} !== 64'h0000_0000_0000_0006) begin
            failures++; $display("[TB] FAIL fix_overwrite: got %h_%h expected 00000000_00000006", ReadHi, ReadLo);
        end
        mHi = 32'h0;
        mLo = 32'h6;
    endtask

    task automatic test_start_while_busy();
        int   cyc;
        int   extraDone;
        logic bok;
        runOp(3'b001, 32'd5, 32'd6, 0, 1'b0, 1'b0, '0, 10, cyc, bok);
        checks++;
        if (cyc !== 34) begin failures++; $display("[TB] FAIL ignored_start_latency: got %0d expected 34", cyc); end
        checks++;
        if ({ReadHi, ReadLo} !== 64'd30) begin
            failures++; $display("[TB] FAIL ignored_start_result: got %h_%h expected 00000000_0000001e", ReadHi, ReadLo);
        end
        extraDone = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Done) extraDone++;
        end
        checks++;
        if (extraDone !== 0) begin failures++; $display("[TB] FAIL ignored_start_done: got %0d extra Done expected 0", extraDone); end
        mHi = 32'h0;
        mLo = 32'd30;
    endtask

    task automatic test_reset_abort();
        int sawDone;
        Start    = 1'b1;
        Op       = 3'b000;
        OperandA = 32'd3;
        OperandB = 32'd3;
        @(negedge Clk);
        Start = 1'b0;
        repeat (9) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        checks++;
        if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy: got %b expected 0", Busy); end
        checks++;
        if ({ReadHi, ReadLo} !== 64'h0) begin failures++; $display("[TB] FAIL abort_hilo: got %h_%h expected 0_0", ReadHi, ReadLo); end
        sawDone = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Done) sawDone++;
        end
        checks++;
        if (sawDone !== 0) begin failures++; $display("[TB] FAIL abort_done: got %0d Done pulses expected 0", sawDone); end
        checks++;
        if ({ReadHi, ReadLo} !== 64'h0) begin failures++; $display("[TB] FAIL abort_no_write: got %h_%h expected 0_0", ReadHi, ReadLo); end
        mHi = '0;
        mLo = '0;
    endtask

    task automatic test_write_visibility();
        logic [W-1:0] expSame;
        LoWrite   = 1'b1;
        WriteData = 32'h1234;
        #1;
`ifdef HILO_BYPASS_EN
        expSame = 32'h1234;
`else
        expSame = mLo;
`endif
        checks++;
        if (ReadLo !== expSame) begin failures++; $display("[TB] FAIL mtlo_same_cycle: got %h expected %h", ReadLo, expSame); end
        @(negedge Clk);
        LoWrite = 1'b0;
        #1;
        checks++;
        if (ReadLo !== 32'h1234) begin failures++; $display("[TB] FAIL mtlo_next_cycle: got %h expected 00001234", ReadLo); end
        HiWrite   = 1'b1;
        WriteData = 32'hCAFE;
        #1;
`ifdef HILO_BYPASS_EN
        expSame = 32'hCAFE;
`else
        expSame = mHi;
`endif
        checks++;
        if (ReadHi !== expSame) begin failures++; $display("[TB] FAIL mthi_same_cycle: got %h expected %h", ReadHi, expSame); end
        @(negedge Clk);
        HiWrite = 1'b0;
        #1;
        checks++;
        if (ReadHi !== 32'hCAFE) begin failures++; $display("[TB] FAIL mthi_next_cycle: got %h expected 0000cafe", ReadHi); end
        mHi = 32'hCAFE;
        mLo = 32'h1234;
        @(negedge Clk);
    endtask

    task automatic test_random();
        int           cyc, wrc, sel;
        logic         bok, hw, lw, ed;
        logic [2:0]   op;
        logic [W-1:0] a, b, wd, eh, el, bh, bl;
        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 5);
            if (sel == 0) b = '0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) begin a = 32'($urandom_range(0, 40)) - 32'd20; b = 32'($urandom_range(0, 10)) - 32'd5; end
            wrc = 0;
            hw  = 1'b0;
            lw  = 1'b0;
            wd  = $urandom;
            bh  = mHi;
            bl  = mLo;
            if ($urandom_range(0, 3) == 0) begin
                wrc = $urandom_range(1, 32);
                hw  = 1'($urandom_range(0, 1));
                lw  = 1'($urandom_range(0, 1));
                if (hw) bh = wd;
                if (lw) bl = wd;
            end
            modelOp(op, a, b, bh, bl, eh, el, ed);
            runOp(op, a, b, wrc, hw, lw, wd, 0, cyc, bok);
            checks++;
            if (cyc !== 34) begin failures++; $display("[TB] FAIL rand_latency[%0d]: got %0d expected 34", i, cyc); end
            checks++;
            if ({ReadHi, ReadLo} !== {eh, el}) begin
                failures++; $display("[TB] FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h_%h expected %h_%h", i, op, a, b, ReadHi, ReadLo, eh, el);
            end
            checks++;
            if (DivByZero !== ed) begin failures++; $display("[TB] FAIL rand_dbz[%0d]: got %b expected %b", i, DivByZero, ed); end
            mHi = eh;
            mLo = el;
        end
    endtask

    // Scenario sequence followed by the summary.
    initial begin
        test_reset();
        test_mult_timing();
        test_back_to_back();
        test_div();
        test_madd_msub();
        test_start_while_busy();
        test_reset_abort();
        test_write_visibility();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
